// File: rtl/hsv_rgb_led_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hsv_rgb_led_driver: multi-cycle HSV->RGB converter feeding three PWM channels |
// | rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
module hsv_rgb_led_driver #(
    parameter int PWM_DIV    = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hue,
    input  logic [8:0] saturation,
    input  logic [8:0] value,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       rgb_valid,
    output logic       busy,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PWM_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [8:0]  r_cap_hue, r_cap_sat, r_cap_val;
    logic [8:0]  r_last_hue, r_last_sat, r_last_val;
    logic        r_last_valid;
    logic [6:0]  r_s, r_v;
    logic [2:0]  r_sector;
    logic [5:0]  r_f;
    logic [21:0] r_num;
    logic [13:0] r_rem;
    logic [4:0]  r_iter;
    logic [1:0]  r_op;
    logic [7:0]  r_c, r_m, r_d;

    logic [8:0]  w_h;
    logic [6:0]  w_s, w_v;
    logic [2:0]  w_sector;
    logic [5:0]  w_f;
    logic        w_new;
    logic [15:0] w_num_c;
    logic [21:0] w_num_m;
    logic [13:0] w_num_d;
    logic [7:0]  w_cm;
    logic [14:0] w_den, w_rem_sh;
    logic        w_ge;
    logic [13:0] w_rem_nx;
    logic [21:0] w_num_sh;
    logic [7:0]  w_quo;
    logic [7:0]  w_rise, w_fall, w_red, w_grn, w_blu;

    always_comb begin
        w_h = (hue >= 9'd360) ? hue - 9'd360 : hue;
        w_s = (saturation > 9'd100) ? 7'd100 : saturation[6:0];
        w_v = (value > 9'd100) ? 7'd100 : value[6:0];
        if (w_h < 9'd60)       w_sector = 3'd0;
        else if (w_h < 9'd120) w_sector = 3'd1;
        else if (w_h < 9'd180) w_sector = 3'd2;
        else if (w_h < 9'd240) w_sector = 3'd3;
        else if (w_h < 9'd300) w_sector = 3'd4;
        else                   w_sector = 3'd5;
        w_f   = 6'(w_h - 9'd60 * 9'(w_sector));
        w_new = !r_last_valid || (hue != r_last_hue) ||
                (saturation != r_last_sat) || (value != r_last_val);
    end

    // Shared restoring divider: numerator MSB-first out of r_num, quotient bits shift in at the LSB.
    always_comb begin
        case (r_op)
            2'd0:    w_den = 15'd100;
            2'd1:    w_den = 15'd10000;
            default: w_den = 15'd60;
        endcase
        w_rem_sh = {r_rem, r_num[21]};
        w_ge     = (w_rem_sh >= w_den);
        w_rem_nx = w_ge ? 14'(w_rem_sh - w_den) : w_rem_sh[13:0];
        w_num_sh = {r_num[20:0], w_ge};
        w_quo    = w_num_sh[7:0];
        w_num_c  = 16'(w_v) * 16'd255;
        w_num_m  = 22'(r_v) * 22'(7'd100 - r_s) * 22'd255;
        w_cm     = r_c - w_quo;
        w_num_d  = 14'(w_cm) * 14'(r_f);
    end

    always_comb begin
        w_rise = r_m + r_d;
        w_fall = r_c - r_d;
        w_red  = r_c;
        w_grn  = w_rise;
        w_blu  = r_m;
        case (r_sector)
            3'd0: begin w_red = r_c;    w_grn = w_rise; w_blu = r_m;    end
            3'd1: begin w_red = w_fall; w_grn = r_c;    w_blu = r_m;    end
            3'd2: begin w_red = r_m;    w_grn = r_c;    w_blu = w_rise; end
            3'd3: begin w_red = r_m;    w_grn = w_fall; w_blu = r_c;    end
            3'd4: begin w_red = w_rise; w_grn = r_m;    w_blu = r_c;    end
            default: begin w_red = r_c; w_grn = r_m;    w_blu = w_fall; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            red          <= 8'd0;
            green        <= 8'd0;
            blue         <= 8'd0;
            rgb_valid    <= 1'b0;
            busy         <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_hue   <= 9'd0;
            r_last_sat   <= 9'd0;
            r_last_val   <= 9'd0;
            r_cap_hue    <= 9'd0;
            r_cap_sat    <= 9'd0;
            r_cap_val    <= 9'd0;
            r_s          <= 7'd0;
            r_v          <= 7'd0;
            r_sector     <= 3'd0;
            r_f          <= 6'd0;
            r_num        <= 22'd0;
            r_rem        <= 14'd0;
            r_iter       <= 5'd0;
            r_op         <= 2'd0;
            r_c          <= 8'd0;
            r_m          <= 8'd0;
            r_d          <= 8'd0;
        end else begin
            rgb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_new) begin
                        r_cap_hue <= hue;
                        r_cap_sat <= saturation;
                        r_cap_val <= value;
                        r_s       <= w_s;
                        r_v       <= w_v;
                        r_sector  <= w_sector;
                        r_f       <= w_f;
                        r_num     <= {w_num_c, 6'd0};
                        r_rem     <= 14'd0;
                        r_iter    <= 5'd15;
                        r_op      <= 2'd0;
                        busy      <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_num <= w_num_sh;
                    if (r_iter != 5'd0) begin
                        r_iter <= r_iter - 5'd1;
                    end else begin
                        r_rem <= 14'd0;
                        case (r_op)
                            2'd0: begin
                                r_c    <= w_quo;
                                r_num  <= w_num_m;
                                r_iter <= 5'd21;
                                r_op   <= 2'd1;
                            end
                            2'd1: begin
                                r_m    <= w_quo;
                                r_num  <= {w_num_d, 8'd0};
                                r_iter <= 5'd13;
                                r_op   <= 2'd2;
                            end
                            default: begin
                                r_d     <= w_quo;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    red          <= w_red;
                    green        <= w_grn;
                    blue         <= w_blu;
                    rgb_valid    <= 1'b1;
                    busy         <= 1'b0;
                    r_last_hue   <= r_cap_hue;
                    r_last_sat   <= r_cap_sat;
                    r_last_val   <= r_cap_val;
                    r_last_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_cnt, r_duty_r, r_duty_g, r_duty_b;

    // Duty registers only reload at the period boundary so a new colour never truncates a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre    <= '0;
            r_cnt    <= 8'd0;
            r_duty_r <= 8'd0;
            r_duty_g <= 8'd0;
            r_duty_b <= 8'd0;
            pwm_r    <= ACTIVE_LOW;
            pwm_g    <= ACTIVE_LOW;
            pwm_b    <= ACTIVE_LOW;
        end else begin
            pwm_r <= (r_cnt < r_duty_r) ^ ACTIVE_LOW;
            pwm_g <= (r_cnt < r_duty_g) ^ ACTIVE_LOW;
            pwm_b <= (r_cnt < r_duty_b) ^ ACTIVE_LOW;
            if (r_pre == c_pre_last) begin
                r_pre <= '0;
                r_cnt <= r_cnt + 8'd1;
                if (r_cnt == 8'hFF) begin
                    r_duty_r <= red;
                    r_duty_g <= green;
                    r_duty_b <= blue;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hsv_rgb_led_driver.sv
`default_nettype none
// Scoreboard bench for hsv_rgb_led_driver: two instances (plain PWM, and prescaled active-low PWM).
module tb_hsv_rgb_led_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hue, saturation, value;
    logic [7:0] red0, green0, blue0, red1, green1, blue1;
    logic       rgb_valid0, busy0, pwm_r0, pwm_g0, pwm_b0;
    logic       rgb_valid1, busy1, pwm_r1, pwm_g1, pwm_b1;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [23:0] e0, e1;
    int          last_h, last_s, last_v;
    bit          last_ok = 1'b0;

    always #5 clk = ~clk;

    hsv_rgb_led_driver #(.PWM_DIV(1), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .reset(reset), .hue(hue), .saturation(saturation), .value(value),
        .red(red0), .green(green0), .blue(blue0), .rgb_valid(rgb_valid0), .busy(busy0),
        .pwm_r(pwm_r0), .pwm_g(pwm_g0), .pwm_b(pwm_b0)
    );

    hsv_rgb_led_driver #(.PWM_DIV(2), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .reset(reset), .hue(hue), .saturation(saturation), .value(value),
        .red(red1), .green(green1), .blue(blue1), .rgb_valid(rgb_valid1), .busy(busy1),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1)
    );

    function automatic logic [23:0] model(input int hue_i, input int sat_i, input int val_i);
        int h, s, v, sec, f, c, m, d, rise, fall, r, g, b;
        h = (hue_i >= 360) ? hue_i - 360 : hue_i;
        s = (sat_i > 100) ? 100 : sat_i;
        v = (val_i > 100) ? 100 : val_i;
        sec  = h / 60;
        f    = h - 60 * sec;
        c    = v * 255 / 100;
        m    = v * (100 - s) * 255 / 10000;
        d    = (c - m) * f / 60;
        rise = m + d;
        fall = c - d;
        case (sec)
            0:       begin r = c;    g = rise; b = m;    end
            1:       begin r = fall; g = c;    b = m;    end
            2:       begin r = m;    g = c;    b = rise; end
            3:       begin r = m;    g = fall; b = c;    end
            4:       begin r = rise; g = m;    b = c;    end
            default: begin r = c;    g = m;    b = fall; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // Monitor: every rgb_valid pops one expected triple per instance.
    always @(negedge clk) begin
        if (rgb_valid0) begin
            pulses++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rgb0_unexpected got %h required no pulse", {red0, green0, blue0});
            end else begin
                e0 = q0.pop_front();
                if ({red0, green0, blue0} !== e0) begin
                    errors++;
                    $display("FAIL rgb0 got %h required %h", {red0, green0, blue0}, e0);
                end
            end
        end
        if (rgb_valid1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rgb1_unexpected got %h required no pulse", {red1, green1, blue1});
            end else begin
                e1 = q1.pop_front();
                if ({red1, green1, blue1} !== e1) begin
                    errors++;
                    $display("FAIL rgb1 got %h required %h", {red1, green1, blue1}, e1);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic expect_rgb(input logic [23:0] exp);
        q0.push_back(exp);
        q1.push_back(exp);
    endtask

    task automatic apply(input int h, input int s, input int v);
        hue = 9'(h);
        saturation = 9'(s);
        value = 9'(v);
        last_h = h;
        last_s = s;
        last_v = v;
        last_ok = 1'b1;
    endtask

    task automatic wait_pulses(input int target);
        int n;
        n = 0;
        while (pulses < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_timeout", pulses, target);
    endtask

    task automatic convert(input int h, input int s, input int v, input logic [23:0] exp);
        int target;
        if (last_ok && h == last_h && s == last_s && v == last_v) return;
        target = pulses + 1;
        expect_rgb(exp);
        apply(h, s, v);
        @(negedge clk);
        chk("busy_during", int'(busy0), 1);
        wait_pulses(target);
        @(negedge clk);
        chk("busy_after", int'(busy0), 0);
    endtask

    task automatic count_high0(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cnt += int'(pwm_r0);
        end
    endtask

    task automatic count_low1(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cnt += int'(!pwm_r1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          target, p, cnt;
        bit          prev, found;
        logic [23:0] ex;

        reset = 1'b1;
        hue = 9'd0;
        saturation = 9'd0;
        value = 9'd0;
        repeat (3) @(negedge clk);
        chk("reset_red", int'(red0), 0);
        chk("reset_valid", int'(rgb_valid0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_pwm0", int'({pwm_r0, pwm_g0, pwm_b0}), 0);
        chk("reset_pwm1_al", int'({pwm_r1, pwm_g1, pwm_b1}), 7);

        // Inputs 0,0,0 still convert once after reset.
        target = pulses + 1;
        expect_rgb(24'h000000);
        apply(0, 0, 0);
        reset = 1'b0;
        wait_pulses(target);
        @(negedge clk);

        convert(0, 100, 100, {8'd255, 8'd0, 8'd0});
        convert(30, 100, 100, {8'd255, 8'd127, 8'd0});
        convert(120, 100, 100, {8'd0, 8'd255, 8'd0});
        convert(300, 100, 100, {8'd255, 8'd0, 8'd255});
        convert(240, 0, 80, {8'd204, 8'd204, 8'd204});
        convert(360, 120, 100, {8'd255, 8'd0, 8'd0});

        // Reset in the middle of a conversion.
        apply(30, 100, 100);
        @(negedge clk);
        chk("busy_before_abort", int'(busy0), 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_red", int'(red0), 0);
        chk("abort_rgb1", int'({red1, green1, blue1}), 0);
        chk("abort_valid", int'(rgb_valid0), 0);
        chk("abort_busy", int'(busy0 | busy1), 0);
        target = pulses + 1;
        expect_rgb({8'd255, 8'd127, 8'd0});
        reset = 1'b0;
        wait_pulses(target);
        @(negedge clk);

        // Input change two cycles after capture.
        target = pulses + 2;
        expect_rgb({8'd255, 8'd0, 8'd0});
        expect_rgb({8'd0, 8'd255, 8'd0});
        apply(0, 100, 100);
        repeat (2) @(negedge clk);
        apply(120, 100, 100);
        wait_pulses(target);
        p = pulses;
        repeat (150) @(negedge clk);
        chk("no_extra_pulse", pulses, p);

        // PWM: duty latched per period, mid-period colour change deferred.
        ex = model(0, 100, 25);
        convert(0, 100, 25, ex);
        repeat (300) @(negedge clk);
        found = 1'b0;
        prev = pwm_r0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (!prev && pwm_r0) found = 1'b1;
            prev = pwm_r0;
        end
        chk("pwm_rise_found", int'(found), 1);
        cnt = int'(pwm_r0);
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            cnt += int'(pwm_r0);
        end
        chk("pwm_duty_a", cnt, int'(ex[23:16]));
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt += int'(pwm_r0);
            if (i == 5) begin
                expect_rgb(model(0, 100, 80));
                apply(0, 100, 80);
            end
        end
        chk("pwm_duty_midchange", cnt, int'(ex[23:16]));
        ex = model(0, 100, 80);
        count_high0(256, cnt);
        chk("pwm_duty_b", cnt, int'(ex[23:16]));

        repeat (600) @(negedge clk);
        found = 1'b0;
        prev = pwm_r1;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (prev && !pwm_r1) found = 1'b1;
            prev = pwm_r1;
        end
        chk("pwm1_fall_found", int'(found), 1);
        cnt = int'(!pwm_r1);
        for (int i = 1; i < 512; i++) begin
            @(negedge clk);
            cnt += int'(!pwm_r1);
        end
        chk("pwm1_active_low", cnt, 2 * int'(ex[23:16]));

        // Duty boundaries 0 and 255.
        convert(0, 100, 0, 24'h000000);
        repeat (600) @(negedge clk);
        count_high0(512, cnt);
        chk("pwm_duty_zero", cnt, 0);
        count_low1(512, cnt);
        chk("pwm1_duty_zero", cnt, 0);
        convert(0, 100, 100, {8'd255, 8'd0, 8'd0});
        repeat (600) @(negedge clk);
        count_high0(256, cnt);
        chk("pwm_duty_full", cnt, 255);
        count_low1(512, cnt);
        chk("pwm1_duty_full", cnt, 510);

        for (int h = 0; h < 360; h++) begin
            int s, v;
            s = int'($urandom_range(0, 110));
            v = int'($urandom_range(0, 110));
            convert(h, s, v, model(h, s, v));
        end
        for (int k = 0; k < 40; k++) begin
            int h, s, v;
            h = int'($urandom_range(0, 511));
            s = int'($urandom_range(0, 511));
            v = int'($urandom_range(0, 511));
            convert(h, s, v, model(h, s, v));
        end

        repeat (10) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
